// File: rtl/sha256_pkg.sv
// Shared constants, types and bit functions for the SHA-256 stream core.
// SHA256_MODE224_EN adds the SHA-224 initial value.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA256_MODE224_EN
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Eight independent 32-bit adds; carries never cross word boundaries.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       st,
  input  logic [31:0] kt,
  input  logic [31:0] wt,
  output work_t       st_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = st.h + big_sigma1(st.e) + ch(st.e, st.f, st.g) + kt + wt;
  assign t2 = big_sigma0(st.a) + maj(st.a, st.b, st.c);

  assign st_next.a = t1 + t2;
  assign st_next.b = st.a;
  assign st_next.c = st.b;
  assign st_next.d = st.c;
  assign st_next.e = st.d + t1;
  assign st_next.f = st.e;
  assign st_next.g = st.f;
  assign st_next.h = st.g;

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine, RPC rounds per clock, valid/ready on both sides.
// SHA256_MODE224_EN adds the mode224 input and SHA-224 output truncation.
//
// state | meaning
// IDLE  | in_ready high, waiting for a block
// RUN   | 64/RPC cycles of compression rounds
// ADD   | fold working vars into the chaining value H
// DONE  | digest_out valid, waiting for out_ready
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic         first,
  input  logic         last,
`ifdef SHA256_MODE224_EN
  input  logic         mode224,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $fatal(1, "sha256_stream_core: RPC must be 1, 2 or 4");
  end

  localparam logic [5:0] LAST_RND = 6'(64 - RPC);

  state_t         state;
  state_t         state_next;
  logic [5:0]     rnd;
  logic [31:0]    w [16];
  logic [31:0]    w_shift [16];
  work_t          work;
  work_t          work_run;
  logic [255:0]   h_q;
  logic [255:0]   h_next;
  logic [255:0]   base;
  logic [255:0]   iv_sel;
  logic [255:0]   digest_mask;
  logic           last_q;
  logic           accept;

`ifdef SHA256_MODE224_EN
  logic mode_q;
  assign iv_sel      = mode224 ? IV224 : IV256;
  assign digest_mask = mode_q ? {{224{1'b1}}, 32'h0} : {256{1'b1}};
`else
  assign iv_sel      = IV256;
  assign digest_mask = {256{1'b1}};
`endif

  assign base = first ? iv_sel : h_q;

  // Round chain: stage j consumes schedule word w[j] and constant K[rnd+j].
  for (genvar j = 0; j < RPC; j = j + 1) begin : g_rnd
    work_t      s_in;
    work_t      s_out;
    logic [5:0] k_idx;
    assign k_idx = rnd + 6'(j);
    if (j == 0) begin : g_head
      assign s_in = work;
    end else begin : g_link
      assign s_in = g_rnd[j-1].s_out;
    end
    sha256_round u_round (
      .st      (s_in),
      .kt      (K[k_idx]),
      .wt      (w[j]),
      .st_next (s_out)
    );
  end
  assign work_run = g_rnd[RPC-1].s_out;

  // New schedule words W[t+16+j]; for j >= 2 the W[t-2] term is itself new this cycle.
  for (genvar j = 0; j < RPC; j = j + 1) begin : g_ext
    logic [31:0] w2;
    logic [31:0] e;
    if (j < 2) begin : g_win
      assign w2 = w[14+j];
    end else begin : g_fwd
      assign w2 = g_ext[j-2].e;
    end
    assign e = small_sigma1(w2) + w[9+j] + small_sigma0(w[1+j]) + w[j];
  end

  for (genvar i = 0; i < 16; i = i + 1) begin : g_shift
    if (i + RPC < 16) begin : g_old
      assign w_shift[i] = w[i+RPC];
    end else begin : g_new
      assign w_shift[i] = g_ext[i+RPC-16].e;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    h_next     = h_q;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = RUN;
          h_next     = base;
        end
      end
      RUN: begin
        if (rnd == LAST_RND) state_next = ADD;
      end
      ADD: begin
        h_next     = add_words(h_q, work);
        state_next = last_q ? DONE : IDLE;
      end
      DONE: begin
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rnd        <= '0;
      work       <= '0;
      h_q        <= IV256;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      digest_out <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
`ifdef SHA256_MODE224_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      h_q        <= h_next;
      in_ready   <= (state_next == IDLE);
      out_valid  <= (state_next == DONE);
      digest_out <= (state_next == DONE) ? (h_next & digest_mask) : '0;
      if (accept) begin
        work   <= base;
        last_q <= last;
        rnd    <= '0;
        for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
`ifdef SHA256_MODE224_EN
        if (first) mode_q <= mode224;
`endif
      end else if (state == RUN) begin
        work <= work_run;
        rnd  <= rnd + 6'(RPC);
        for (int i = 0; i < 16; i++) w[i] <= w_shift[i];
      end
    end
  end

endmodule
